// File: rtl/sd_pio_pkg.sv
// Shared constants for the SD-card input PIO: register word addresses and edge-select codes.
package sd_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Selects the capture condition for one bit according to the edge-type encoding.
  function automatic logic edge_sel(input int unsigned edge_type, input logic rise,
                                    input logic fall);
    if (edge_type == EDGE_RISE) begin
      return rise;
    end else if (edge_type == EDGE_FALL) begin
      return fall;
    end
    return rise | fall;
  endfunction

endpackage

// File: rtl/sd_pio_debounce.sv
// One input bit: two-flop synchroniser followed by an optional stable-count debouncer.
module sd_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable
);

  logic sync1_q, sync2_q, stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_bit;
      sync2_q <= sync1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable_q <= 1'b0;
      end else begin
        stable_q <= sync2_q;
      end
    end
  end else begin : g_count
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_nx;

    // Counter only advances while sync2 disagrees with stable, so it tops out at CntLast.
    always_comb begin
      cnt_d     = cnt_q;
      stable_nx = stable_q;
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        stable_nx = sync2_q;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_nx;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sd_card_pio_in.sv
// Avalon-MM input PIO for SD-card status pins: debounced data, edge capture and masked IRQ.
module sd_card_pio_in
  import sd_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] set_vec, clr;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sd_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[i]),
      .stable(stable[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    set_vec   = '0;
    clr       = '0;
    irqmask_d = irqmask_q;
    for (int i = 0; i < WIDTH; i++) begin
      set_vec[i] = edge_sel(EDGE_TYPE, stable[i] & ~stable_dly_q[i],
                            ~stable[i] & stable_dly_q[i]);
    end
    if (wr_en && address == ADDR_EDGECAP) begin
      clr = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // Set has priority over a simultaneous clear.
    edgecap_d = set_vec | (edgecap_q & ~clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_dly_q <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
    end else begin
      stable_dly_q <= stable;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule
